fa_stim_checker: RTL and testbench
==================================

// Module: fa_stim_checker
// PURPOSE
//  Self-checking driver on the tb end of adder_intf: connects through modport tb, drives a/b/cin, samples s/c.
//  On start, sweeps all 8 input vectors NUM_PASSES times and compares each response to a golden full-adder model.
//  Counts mismatches and reports done/pass. Sits beside any full-adder DUT as the BIST/bench stimulus engine.
// PARAMETERS
//  NUM_PASSES  1  full 8-vector sweeps per run (>=1)
//  SETTLE_CYC  1  cycles between driving a vector and sampling its response (>=1)
//  ERR_W       8  width of error counter
// PORTS
//  clk      in   1      clock, rising edge
//  rst_n    in   1      synchronous active-low reset
//  start    in   1      pulse; begins a run when not busy
//  inf      if   -      adder_intf.tb: a,b,cin driven (registered), s,c sampled
//  busy     out  1      run in progress
//  done     out  1      run complete; level, held until next start or reset
//  pass     out  1      done && err_cnt==0
//  err_cnt  out  ERR_W  mismatches this run, saturating
// BEHAVIOUR
//  - Reset (rst_n==0 at clk edge): state IDLE; a=b=cin=0; busy=done=pass=0; err_cnt=0; vec=0; pass_idx=0.
//  - Vector mapping: vec[2]=a, vec[1]=b, vec[0]=cin. Expected s=a^b^cin, c=majority(a,b,cin).
//  - FSM IDLE -> SETTLE -> CHECK -> (SETTLE | DONE) -> IDLE on start.
//  - IDLE/DONE + start: vec<=0, pass_idx<=0, err_cnt<=0, done<=0, settle cnt<=SETTLE_CYC-1, busy<=1 -> SETTLE.
//  - SETTLE: hold a/b/cin=vec; decrement; at 0 -> CHECK.
//  - CHECK: compare {inf.c,inf.s} to fa_ref(vec); mismatch -> err_cnt+1, saturating at all-ones.
//      vec==7 && pass_idx==NUM_PASSES-1 -> DONE (busy<=0, done<=1); else vec<=vec+1 (7 wraps to 0, pass_idx+1) -> SETTLE.
//  - Per-vector cost SETTLE_CYC+1 cycles; done rises NUM_PASSES*8*(SETTLE_CYC+1) cycles after the start edge.
//  - start while busy: ignored, no restart, no counter change.
//  - DONE: a/b/cin hold last vector (3'b111); err_cnt and pass stable.
//  - Reset mid-run: aborts immediately to reset values; no partial done/pass reported.
//  - X/Z on s/c counts as mismatch (use !== in compare).
// CONFIGURATION
//  FA_CHK_FAIL_CAPTURE_EN defined: adds outputs first_fail_vec[2:0] and first_fail_resp[1:0] ({c,s} observed).
//   Loaded on the first mismatch of a run only; cleared to 0 on reset and on accepted start.
//   first_fail_valid out 1 indicates capture occurred.
//  Undefined: these ports and registers do not exist; all other behaviour identical.
// STRUCTURE
//  Package fa_chk_pkg:
//   - typedef enum logic [1:0] {IDLE,SETTLE,CHECK,DONE} fa_chk_state_e;
//   - function automatic logic [1:0] fa_ref(logic [2:0] v) returning {c,s}.
//   - localparam NUM_VECS = 8.
//  No sub-module; golden model is the package function. Counters and FSM live in one always_ff.
// TESTING
//  1. Correct FA, NUM_PASSES=1, SETTLE_CYC=1, start pulse at cycle 0 -> done rises after 16 cycles, err_cnt=0, pass=1.
//  2. DUT with s/c swapped -> vectors 001,010,011,100,101,110 fail -> err_cnt=6, pass=0;
//     with FA_CHK_FAIL_CAPTURE_EN: first_fail_vec=3'b001, first_fail_resp=2'b10.
//  3. Swapped DUT, ERR_W=2 -> err_cnt saturates at 3, no wrap to 0; pass=0.
//  4. NUM_PASSES=3, SETTLE_CYC=2, correct FA -> done after 72 cycles; a/b/cin sequence 0..7 repeated 3x.
//  5. rst_n low 1 cycle while vec=4 -> next edge a=b=cin=0, busy=0, done=0, err_cnt=0; new start then runs full 16 cycles.
//  6. Extra start pulses mid-run -> ignored, done still at cycle 16; start in DONE -> done drops, err_cnt clears, rerun.

Source files
------------

// File: rtl/fa_stim_checker_pkg.sv
// Shared types and golden full-adder model for fa_stim_checker.
package fa_chk_pkg;

  localparam int NUM_VECS = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } fa_chk_state_e;

  function automatic logic [1:0] fa_ref(input logic [2:0] v);
    logic a, b, cin;
    a   = v[2];
    b   = v[1];
    cin = v[0];
    return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/fa_stim_checker_if.sv
// Full-adder connection: tb side drives a/b/cin, dut side returns s/c.
interface adder_intf;
  logic a;
  logic b;
  logic cin;
  logic s;
  logic c;

  modport tb (
    output a, b, cin,
    input  s, c
  );

  modport dut (
    input  a, b, cin,
    output s, c
  );
endinterface

// File: rtl/fa_stim_checker.sv
// Sweeps all 8 vectors into a full adder and counts mismatches.
// Optional FA_CHK_FAIL_CAPTURE_EN adds first-failure capture ports.
module fa_stim_checker
  import fa_chk_pkg::*;
#(
  parameter int NUM_PASSES = 1,
  parameter int SETTLE_CYC = 1,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  adder_intf.tb            inf,
  output logic             busy,
  output logic             done,
  output logic             pass,
`ifdef FA_CHK_FAIL_CAPTURE_EN
  output logic [2:0]       first_fail_vec,
  output logic [1:0]       first_fail_resp,
  output logic             first_fail_valid,
`endif
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CNT_W =
    (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int PI_W =
    (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(SETTLE_CYC - 1);
  localparam logic [PI_W-1:0] PI_LAST =
    PI_W'(NUM_PASSES - 1);
  localparam logic [2:0] VEC_LAST = 3'(NUM_VECS - 1);

  fa_chk_state_e    state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [PI_W-1:0]  pidx_q, pidx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       resp;
  logic             miss;

`ifdef FA_CHK_FAIL_CAPTURE_EN
  logic [2:0] ffv_q, ffv_d;
  logic [1:0] ffr_q, ffr_d;
  logic       ffok_q, ffok_d;
`endif

  assign resp = {inf.c, inf.s};
  // X/Z on the response must count as a miss
  assign miss = (resp !== fa_ref(vec_q));

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    pidx_d  = pidx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef FA_CHK_FAIL_CAPTURE_EN
    ffv_d   = ffv_q;
    ffr_d   = ffr_q;
    ffok_d  = ffok_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d   = '0;
          pidx_d  = '0;
          err_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
`ifdef FA_CHK_FAIL_CAPTURE_EN
          ffv_d   = '0;
          ffr_d   = '0;
          ffok_d  = 1'b0;
`endif
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      CHECK: begin
        if (miss) begin
          if (err_q != '1) err_d = err_q + 1'b1;
`ifdef FA_CHK_FAIL_CAPTURE_EN
          if (!ffok_q) begin
            ffv_d  = vec_q;
            ffr_d  = resp;
            ffok_d = 1'b1;
          end
`endif
        end
        if (vec_q == VEC_LAST && pidx_q == PI_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          vec_d = vec_q + 1'b1;
          if (vec_q == VEC_LAST) pidx_d = pidx_q + 1'b1;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      pidx_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FA_CHK_FAIL_CAPTURE_EN
      ffv_q   <= '0;
      ffr_q   <= '0;
      ffok_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pidx_q  <= pidx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FA_CHK_FAIL_CAPTURE_EN
      ffv_q   <= ffv_d;
      ffr_q   <= ffr_d;
      ffok_q  <= ffok_d;
`endif
    end
  end

  // Stimulus is the vector register itself, so it is registered
  assign inf.a   = vec_q[2];
  assign inf.b   = vec_q[1];
  assign inf.cin = vec_q[0];

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = done_q && (err_q == '0);
  assign err_cnt = err_q;

`ifdef FA_CHK_FAIL_CAPTURE_EN
  assign first_fail_vec   = ffv_q;
  assign first_fail_resp  = ffr_q;
  assign first_fail_valid = ffok_q;
`endif

endmodule

// File: tb/tb_fa_stim_checker.sv
// Bench: four checker instances (good/swapped adders, varied params).
// Checked each cycle against an arithmetic model plus literals.
module tb_fa_stim_checker;

  localparam int NP [4] = '{1, 1, 1, 3};
  localparam int SC [4] = '{1, 1, 1, 2};
  localparam int SW [4] = '{0, 1, 1, 0};
  localparam int EW [4] = '{8, 8, 2, 8};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start_v;
  logic [3:0] busy_v, done_v, pass_v;
  logic [7:0] err_v [4];
  logic [2:0] abc_v [4];
  logic [1:0] err2;

  int n_chk  = 0;
  int n_fail = 0;

  int mn  [4];
  bit mst [4];

  always #5 clk = ~clk;

  adder_intf inf0 ();
  adder_intf inf1 ();
  adder_intf inf2 ();
  adder_intf inf3 ();

  // Adders: 0 and 3 correct, 1 and 2 with s/c swapped
  assign {inf0.c, inf0.s} = 2'(inf0.a) + 2'(inf0.b) + 2'(inf0.cin);
  assign {inf3.c, inf3.s} = 2'(inf3.a) + 2'(inf3.b) + 2'(inf3.cin);
  assign {inf1.s, inf1.c} = 2'(inf1.a) + 2'(inf1.b) + 2'(inf1.cin);
  assign {inf2.s, inf2.c} = 2'(inf2.a) + 2'(inf2.b) + 2'(inf2.cin);

  assign abc_v[0] = {inf0.a, inf0.b, inf0.cin};
  assign abc_v[1] = {inf1.a, inf1.b, inf1.cin};
  assign abc_v[2] = {inf2.a, inf2.b, inf2.cin};
  assign abc_v[3] = {inf3.a, inf3.b, inf3.cin};
  assign err_v[2] = {6'd0, err2};

`ifdef FA_CHK_FAIL_CAPTURE_EN
  logic [3:0] ffok_v;
  logic [2:0] ffv_v [4];
  logic [1:0] ffr_v [4];
`endif

  fa_stim_checker #(.NUM_PASSES(1), .SETTLE_CYC(1), .ERR_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .inf(inf0),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
`ifdef FA_CHK_FAIL_CAPTURE_EN
    .first_fail_vec(ffv_v[0]), .first_fail_resp(ffr_v[0]),
    .first_fail_valid(ffok_v[0]),
`endif
    .err_cnt(err_v[0]));

  fa_stim_checker #(.NUM_PASSES(1), .SETTLE_CYC(1), .ERR_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .inf(inf1),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
`ifdef FA_CHK_FAIL_CAPTURE_EN
    .first_fail_vec(ffv_v[1]), .first_fail_resp(ffr_v[1]),
    .first_fail_valid(ffok_v[1]),
`endif
    .err_cnt(err_v[1]));

  fa_stim_checker #(.NUM_PASSES(1), .SETTLE_CYC(1), .ERR_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .inf(inf2),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
`ifdef FA_CHK_FAIL_CAPTURE_EN
    .first_fail_vec(ffv_v[2]), .first_fail_resp(ffr_v[2]),
    .first_fail_valid(ffok_v[2]),
`endif
    .err_cnt(err2));

  fa_stim_checker #(.NUM_PASSES(3), .SETTLE_CYC(2), .ERR_W(8)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .inf(inf3),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]),
`ifdef FA_CHK_FAIL_CAPTURE_EN
    .first_fail_vec(ffv_v[3]), .first_fail_resp(ffr_v[3]),
    .first_fail_valid(ffok_v[3]),
`endif
    .err_cnt(err_v[3]));

  task automatic chk(input string nm, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got %0h, want %0h",
               nm, inst, $time, act, exp);
    end
  endtask

  function automatic int run_len(input int i);
    return NP[i] * 8 * (SC[i] + 1);
  endfunction

  // Response this instance's adder gives for vector j, vs true sum
  function automatic bit vec_bad(input int i, input int j);
    int sum;
    logic [1:0] obs;
    sum = j[2] + j[1] + j[0];
    obs = SW[i] != 0 ? {1'(sum), 1'(sum >> 1)} : 2'(sum);
    return obs != 2'(sum);
  endfunction

  // Protocol-level model: cycles since the accepted start
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        mst[i] <= 1'b0;
        mn[i]  <= 0;
      end else if (start_v[i] && !(mst[i] && mn[i] < run_len(i))) begin
        mst[i] <= 1'b1;
        mn[i]  <= 0;
      end else if (mst[i] && mn[i] < run_len(i)) begin
        mn[i] <= mn[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      int nchk, errs, emax, vec;
      bit bz, dn;
      nchk = 0; errs = 0; vec = 0; bz = 0; dn = 0;
      emax = (1 << EW[i]) - 1;
      if (mst[i]) begin
        nchk = mn[i] / (SC[i] + 1);
        bz   = mn[i] < run_len(i);
        dn   = !bz;
        vec  = bz ? nchk % 8 : 7;
        for (int j = 0; j < nchk; j++)
          if (vec_bad(i, j % 8) && errs < emax) errs++;
      end
      chk("busy", i, 32'(busy_v[i]), 32'(bz));
      chk("done", i, 32'(done_v[i]), 32'(dn));
      chk("pass", i, 32'(pass_v[i]), 32'(dn && errs == 0));
      chk("err_cnt", i, 32'(err_v[i]), 32'(errs));
      chk("abc", i, 32'(abc_v[i]), 32'(vec));
`ifdef FA_CHK_FAIL_CAPTURE_EN
      begin
        bit fv;
        int fj;
        fv = 0; fj = 0;
        for (int j = nchk - 1; j >= 0; j--)
          if (vec_bad(i, j % 8)) begin fv = 1; fj = j % 8; end
        chk("ff_valid", i, 32'(ffok_v[i]), 32'(fv));
        chk("ff_vec", i, 32'(ffv_v[i]), 32'(fv ? fj : 0));
        chk("ff_resp", i, 32'(ffr_v[i]),
            32'(fv ? {1'(fj[2] + fj[1] + fj[0]),
                      1'((fj[2] + fj[1] + fj[0]) >> 1)} : 0));
      end
`endif
    end
  end

  task automatic edges(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    start_v = 4'h0;
    edges(3);
    chk("rst_busy", 0, 32'(busy_v[0]), 32'd0);
    chk("rst_abc", 0, 32'(abc_v[0]), 32'd0);
    chk("rst_err", 1, 32'(err_v[1]), 32'd0);
    rst_n = 1'b1;
    edges(1);

    // Start all four; this edge is cycle 0
    start_v = 4'hF;
    edges(1);
    start_v = 4'h0;
    chk("busy_on", 0, 32'(busy_v[0]), 32'd1);
    edges(4);
    start_v = 4'b0001;
    edges(1);
    start_v = 4'h0;
    edges(10);
    chk("done_c15", 0, 32'(done_v[0]), 32'd0);
    edges(1);
    chk("done_c16", 0, 32'(done_v[0]), 32'd1);
    chk("pass_good", 0, 32'(pass_v[0]), 32'd1);
    chk("err_swap", 1, 32'(err_v[1]), 32'd6);
    chk("pass_swap", 1, 32'(pass_v[1]), 32'd0);
    chk("err_sat", 2, 32'(err_v[2]), 32'd3);
`ifdef FA_CHK_FAIL_CAPTURE_EN
    chk("ffvec_lit", 1, 32'(ffv_v[1]), 32'd1);
    chk("ffresp_lit", 1, 32'(ffr_v[1]), 32'd2);
`endif
    edges(55);
    chk("done_c71", 3, 32'(done_v[3]), 32'd0);
    edges(1);
    chk("done_c72", 3, 32'(done_v[3]), 32'd1);
    chk("abc_hold", 3, 32'(abc_v[3]), 32'd7);

    // Restart from DONE
    start_v = 4'b0011;
    edges(1);
    start_v = 4'h0;
    chk("redo_done", 0, 32'(done_v[0]), 32'd0);
    chk("redo_err", 1, 32'(err_v[1]), 32'd0);
    chk("redo_busy", 1, 32'(busy_v[1]), 32'd1);
    edges(8);
    chk("vec4", 0, 32'(abc_v[0]), 32'd4);

    // Abort mid-run
    rst_n = 1'b0;
    edges(1);
    rst_n = 1'b1;
    chk("abort_abc", 0, 32'(abc_v[0]), 32'd0);
    chk("abort_busy", 0, 32'(busy_v[0]), 32'd0);
    chk("abort_done", 0, 32'(done_v[0]), 32'd0);
    chk("abort_err", 1, 32'(err_v[1]), 32'd0);

    start_v = 4'b0001;
    edges(1);
    start_v = 4'h0;
    edges(15);
    chk("rerun_c15", 0, 32'(done_v[0]), 32'd0);
    edges(1);
    chk("rerun_c16", 0, 32'(done_v[0]), 32'd1);
    edges(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
